// File: rtl/mod_final_correct_if.sv
// rtl/mod_final_correct_if.sv - start/result handshake bundle for the final-correction stage
interface mod_final_correct_if #(
   parameter int WIDTH = 3072,
   parameter int XW    = WIDTH + 2
);
   logic             en;
   logic [XW-1:0]    x;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] r;
   logic             en_out;
   logic             busy;

   modport master (output en, x, m, input r, en_out, busy);
   modport slave  (input en, x, m, output r, en_out, busy);
endinterface

// File: rtl/mod_final_correct.sv
// rtl/mod_final_correct.sv - constant-time limb-serial final modular correction (NSUB subtract passes)
module mod_final_correct #(
   parameter int WIDTH = 3072,
   parameter int LIMB  = 128,
   parameter int NSUB  = 3
) (
   input logic               clk,
   input logic               rst,
   mod_final_correct_if.slave bus
);
   localparam int XW    = WIDTH + 2;
   localparam int NLIMB = (XW + LIMB - 1) / LIMB;
   localparam int PW    = NLIMB * LIMB;
   localparam int LW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
   localparam int SW    = $clog2(NSUB + 1);
   localparam logic [LW-1:0] LAST_LIMB = LW'(NLIMB - 1);
   localparam logic [SW-1:0] LAST_PASS = SW'(NSUB - 1);

   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    acc, mreg, shadow, diff_full;
   logic [LW-1:0]    limb;
   logic [SW-1:0]    pass;
   logic             borrow;
   logic [LIMB:0]    diff;
   logic [31:0]      base;
   logic             last_limb;
   logic [WIDTH-1:0] r_reg;
   logic             en_out_reg;

   assign base      = 32'(limb) * 32'(LIMB);
   assign last_limb = (limb == LAST_LIMB);

   // Current limb difference with borrow; the committed value splices it onto the shadow limbs.
   always_comb begin
      diff      = {1'b0, acc[base +: LIMB]} - {1'b0, mreg[base +: LIMB]} - {{LIMB{1'b0}}, borrow};
      diff_full = shadow;
      diff_full[PW-1 -: LIMB] = diff[LIMB-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.en) state_nxt = SUB;
         SUB:     if (last_limb && pass == LAST_PASS) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         mreg       <= '0;
         shadow     <= '0;
         limb       <= '0;
         pass       <= '0;
         borrow     <= 1'b0;
         r_reg      <= '0;
         en_out_reg <= 1'b0;
      end else begin
         en_out_reg <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.en) begin
                  acc    <= PW'(bus.x);
                  mreg   <= PW'(bus.m);
                  limb   <= '0;
                  pass   <= '0;
                  borrow <= 1'b0;
               end
            end
            SUB: begin
               shadow[base +: LIMB] <= diff[LIMB-1:0];
               if (last_limb) begin
                  // Commit only when the whole-word subtraction did not underflow.
                  if (!diff[LIMB]) acc <= diff_full;
                  borrow <= 1'b0;
                  limb   <= '0;
                  pass   <= pass + 1'b1;
               end else begin
                  borrow <= diff[LIMB];
                  limb   <= limb + 1'b1;
               end
            end
            DONE: begin
               r_reg      <= acc[WIDTH-1:0];
               en_out_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.r      = r_reg;
   assign bus.en_out = en_out_reg;
   assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_mod_final_correct.sv
// tb/tb_mod_final_correct.sv - bench for mod_final_correct (small 16/4/3 and full 3072/128/3 configs)
module tb_mod_final_correct;
   localparam int SLAT = 16;
   localparam int BLAT = 76;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mod_final_correct_if #(.WIDTH(16),   .XW(18))   s_if ();
   mod_final_correct_if #(.WIDTH(3072), .XW(3074)) b_if ();

   mod_final_correct #(.WIDTH(16), .LIMB(4), .NSUB(3)) dut_s (.clk(clk), .rst(rst), .bus(s_if.slave));
   mod_final_correct #(.WIDTH(3072), .LIMB(128), .NSUB(3)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [17:0] x;
      logic [15:0] m;
      logic [15:0] r;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_wide(input string name, input logic [3071:0] act, input logic [3071:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got low64 %h expected low64 %h", name, act[63:0], exp[63:0]);
      end
   endtask

   // Each pass subtracts m only while the value is still >= m, capped at 3 passes.
   function automatic logic [15:0] model_s(input logic [17:0] x, input logic [15:0] m);
      longint unsigned xx, mm, kk;
      xx = 64'(x);
      mm = 64'(m);
      if (mm == 0) return x[15:0];
      kk = xx / mm;
      if (kk > 3) kk = 3;
      return 16'(xx - kk * mm);
   endfunction

   task automatic run_s(input logic [17:0] x, input logic [15:0] m,
                        output logic [15:0] r, output int lat, output int busy_cnt);
      @(negedge clk);
      s_if.en = 1'b1; s_if.x = x; s_if.m = m;
      @(posedge clk); #1;
      lat = -1;
      busy_cnt = s_if.busy ? 1 : 0;
      @(negedge clk);
      s_if.en = 1'b0; s_if.x = 18'($urandom); s_if.m = 16'($urandom);
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (s_if.busy) busy_cnt++;
         if (s_if.en_out) begin
            lat = c;
            break;
         end
      end
      r = s_if.r;
      if (lat != -1) begin
         @(posedge clk); #1;
         check("en_out_single_pulse", 64'(s_if.en_out), 64'd0);
      end
   endtask

   task automatic run_b(input logic [3073:0] x, input logic [3071:0] m,
                        output logic [3071:0] r, output int lat);
      @(negedge clk);
      b_if.en = 1'b1; b_if.x = x; b_if.m = m;
      @(posedge clk);
      lat = -1;
      @(negedge clk);
      b_if.en = 1'b0; b_if.x = '0; b_if.m = '0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (b_if.en_out) begin
            lat = c;
            break;
         end
      end
      r = b_if.r;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      logic [15:0] r;
      logic [17:0] rx;
      logic [15:0] rm;
      int lat, bc, eo_cnt, eo_at, lat2;
      logic [15:0] got_r, r2;
      logic [3071:0] bm, by, br;
      logic [3073:0] bx;
      int blat;

      vecs[0] = '{x: 18'd5,       m: 16'd7,      r: 16'd5};
      vecs[1] = '{x: 18'd21,      m: 16'd7,      r: 16'd0};
      vecs[2] = '{x: 18'd27,      m: 16'd7,      r: 16'd6};
      vecs[3] = '{x: 18'h2FFFF,   m: 16'hFFFF,   r: 16'h0002};
      vecs[4] = '{x: 18'd13,      m: 16'd5,      r: 16'd3};
      vecs[5] = '{x: 18'h01234,   m: 16'h0000,   r: 16'h1234};
      vecs[6] = '{x: 18'd0,       m: 16'd7,      r: 16'd0};
      vecs[7] = '{x: 18'h0FFFE,   m: 16'hFFFF,   r: 16'hFFFE};
      vecs[8] = '{x: 18'h2FFFD,   m: 16'hFFFF,   r: 16'h0000};
      vecs[9] = '{x: 18'h3FFFF,   m: 16'hFFFF,   r: 16'h0002};

      s_if.en = 1'b0; s_if.x = '0; s_if.m = '0;
      b_if.en = 1'b0; b_if.x = '0; b_if.m = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_r",      64'(s_if.r),      64'd0);
      check("reset_busy",   64'(s_if.busy),   64'd0);
      check("reset_en_out", 64'(s_if.en_out), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_s(vecs[i].x, vecs[i].m, r, lat, bc);
         check($sformatf("vec%0d_r", i),       64'(r),   64'(vecs[i].r));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(SLAT));
         check($sformatf("vec%0d_busy", i),    64'(bc),  64'(SLAT));
      end

      for (int i = 0; i < 30; i++) begin
         rm = (i % 8 == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         if (rm == 0 || i % 5 == 0) rx = 18'($urandom);
         else rx = 18'($urandom % (4 * int'(rm)));
         run_s(rx, rm, r, lat, bc);
         check($sformatf("rand%0d_r", i),       64'(r),   64'(model_s(rx, rm)));
         check($sformatf("rand%0d_latency", i), 64'(lat), 64'(SLAT));
      end

      // en while busy (cycle 3 and the DONE cycle 16) is ignored; cycle 17 is accepted
      @(negedge clk);
      s_if.en = 1'b1; s_if.x = 18'd27; s_if.m = 16'd7;
      @(posedge clk);
      eo_cnt = 0; eo_at = -1; got_r = '0;
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         s_if.en = (c == 3 || c == 16 || c == 17);
         s_if.x = 18'd1; s_if.m = 16'd7;
         @(posedge clk); #1;
         if (s_if.en_out) begin
            eo_cnt++; eo_at = c; got_r = s_if.r;
         end
      end
      @(negedge clk);
      s_if.en = 1'b0;
      check("busy_en_single_en_out", 64'(eo_cnt), 64'd1);
      check("busy_en_en_out_cycle",  64'(eo_at),  64'(SLAT));
      check("busy_en_r",             64'(got_r),  64'd6);
      lat2 = -1; r2 = '0;
      for (int c = 18; c <= 60; c++) begin
         @(posedge clk); #1;
         if (s_if.en_out) begin
            lat2 = c; r2 = s_if.r;
            break;
         end
      end
      check("accept_after_done_cycle", 64'(lat2), 64'(17 + SLAT));
      check("accept_after_done_r",     64'(r2),   64'd1);

      // asynchronous reset mid-job aborts without an en_out
      @(negedge clk);
      s_if.en = 1'b1; s_if.x = 18'd27; s_if.m = 16'd7;
      @(posedge clk);
      @(negedge clk);
      s_if.en = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_r",      64'(s_if.r),      64'd0);
      check("abort_busy",   64'(s_if.busy),   64'd0);
      check("abort_en_out", 64'(s_if.en_out), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      eo_cnt = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (s_if.en_out) eo_cnt++;
      end
      check("abort_no_en_out", 64'(eo_cnt), 64'd0);
      run_s(18'd13, 16'd5, r, lat, bc);
      check("after_abort_r",       64'(r),   64'd3);
      check("after_abort_latency", 64'(lat), 64'(SLAT));

      // full-size: x = y + k*m must reduce to y with fixed latency
      for (int t = 0; t < 2; t++) begin
         for (int w = 0; w < 96; w++) begin
            bm[w*32 +: 32] = $urandom;
            by[w*32 +: 32] = $urandom;
         end
         bm[3071] = 1'b1;
         by[3071] = 1'b0;
         for (int k = 0; k < 4; k++) begin
            bx = {2'b00, by} + 3074'(k) * {2'b00, bm};
            run_b(bx, bm, br, blat);
            check_wide($sformatf("full%0d_k%0d_r", t, k), br, by);
            check($sformatf("full%0d_k%0d_latency", t, k), 64'(blat), 64'(BLAT));
         end
         for (int w = 0; w < 97; w++) bx[w*32 +: 32] = $urandom;
         bx = bx % {bm, 2'b00};
         run_b(bx, bm, br, blat);
         check_wide($sformatf("full%0d_mod_r", t), br, 3072'(bx % {2'b00, bm}));
         check($sformatf("full%0d_mod_latency", t), 64'(blat), 64'(BLAT));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
